ntt_gs_addsub_pipe: RTL and testbench

- Pipelined modular add/sub front end of the INTT Gentleman-Sande butterfly.
- Accepts coefficient pairs (u, v), both in [0, PRIME-1].
- Produces sum = (u+v) mod PRIME and diff = (u-v) mod PRIME.
- Feeds the div2 stage (sum path) and the twiddle multiplier (diff path) with a valid/ready handshake and full backpressure.

---
 rtl/ntt_gs_addsub_pipe.sv | 165 ++++++++++++++++
 tb/tb_ntt_gs_addsub_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_gs_addsub_pipe.sv
// -----------------------------------------------------------------------------
// ntt_gs_addsub_pipe
//
// Pipelined modular add/sub front end of the INTT Gentleman-Sande butterfly.
// For each accepted coefficient pair (u, v), both in [0, PRIME-1], it produces
//   sum  = (u + v) mod PRIME   (feeds the div2 stage)
//   diff = (u - v) mod PRIME   (feeds the twiddle multiplier)
//
// Two register stages (S1: raw add/sub with carry/borrow, S2: modular
// correction). S2 drives the outputs. Latency is 2 cycles and throughput is
// 1 pair/cycle. Valid/ready on both sides with full backpressure. ready_o is
// combinational from ready_i because there is no skid buffer.
//
// Optional feature (compile-time macro NTT_ADDSUB_SUM_DIV2_EN):
//   when defined, S2 also halves the reduced sum modulo PRIME, so that
//   sum_o = (u + v) / 2 mod PRIME and the downstream div2 stage can be
//   bypassed. Latency is unchanged.
//
// Ports:
//   clk      in   1         clock
//   rst      in   1         synchronous active-high reset
//   zeroize  in   1         synchronous clear, same effect as rst
//   valid_i  in   1         input pair valid
//   ready_o  out  1         block accepts a pair this cycle
//   u_i      in   REG_SIZE  first operand  (< PRIME)
//   v_i      in   REG_SIZE  second operand (< PRIME)
//   valid_o  out  1         output pair valid
//   ready_i  in   1         downstream accepts the output this cycle
//   sum_o    out  REG_SIZE  (u+v) mod PRIME, or its half with the feature on
//   diff_o   out  REG_SIZE  (u-v) mod PRIME
// -----------------------------------------------------------------------------
module ntt_gs_addsub_pipe #(
  parameter int unsigned         REG_SIZE       = 23,
  parameter logic [REG_SIZE-1:0] PRIME          = 23'd8380417,
  parameter logic [REG_SIZE-1:0] PRIME_DIV2_ODD = REG_SIZE'((PRIME + 1) / 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                zeroize,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [REG_SIZE-1:0] u_i,
  input  logic [REG_SIZE-1:0] v_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [REG_SIZE-1:0] sum_o,
  output logic [REG_SIZE-1:0] diff_o
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity. The halving constant is only meaningful
  // for an odd modulus, and a mismatched override would silently corrupt the
  // optional halving path.
  // ---------------------------------------------------------------------------
  if (PRIME[0] != 1'b1) begin : g_prime_not_odd
    $error("ntt_gs_addsub_pipe: PRIME must be odd");
  end

  if (PRIME_DIV2_ODD != REG_SIZE'((PRIME + 1) / 2)) begin : g_bad_half_const
    $error("ntt_gs_addsub_pipe: PRIME_DIV2_ODD must equal (PRIME+1)/2");
  end

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic                s1_valid;
  logic [REG_SIZE:0]   s1_sum;   // raw u+v, MSB is the carry
  logic [REG_SIZE:0]   s1_dif;   // raw u-v, MSB is the borrow

  logic                s2_valid;
  logic [REG_SIZE-1:0] s2_sum;
  logic [REG_SIZE-1:0] s2_dif;

  logic                clear;
  logic                adv1;
  logic                adv2;

  // Combinational S2 inputs
  logic [REG_SIZE-1:0] sum_red;
  logic [REG_SIZE-1:0] sum_next;
  logic [REG_SIZE-1:0] dif_next;

  assign clear = rst | zeroize;

  // ---------------------------------------------------------------------------
  // Flow control. A stage advances when it is empty or its successor advances,
  // so a full pipeline with a stalled sink backs up all the way to ready_o.
  // ---------------------------------------------------------------------------
  assign adv2    = !s2_valid || ready_i;
  assign adv1    = !s1_valid || adv2;
  assign ready_o = adv1;

  // ---------------------------------------------------------------------------
  // S2 datapath: single conditional subtract / add folds the raw result back
  // into [0, PRIME-1]. The subtraction is done on the low REG_SIZE bits only;
  // wrap-around modulo 2^REG_SIZE yields the exact result because the reduced
  // value is known to fit.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    sum_red  = s1_sum[REG_SIZE-1:0];
    sum_next = '0;
    dif_next = s1_dif[REG_SIZE-1:0];

    if (s1_sum >= {1'b0, PRIME}) begin
      sum_red = s1_sum[REG_SIZE-1:0] - PRIME;
    end

    if (s1_dif[REG_SIZE]) begin
      dif_next = s1_dif[REG_SIZE-1:0] + PRIME;
    end

`ifdef NTT_ADDSUB_SUM_DIV2_EN
    // Halving modulo an odd PRIME: an odd value x becomes (x+PRIME)/2, which
    // equals (x>>1) + (PRIME+1)/2 without needing an extra carry bit.
    if (sum_red[0]) begin
      sum_next = (sum_red >> 1) + PRIME_DIV2_ODD;
    end else begin
      sum_next = sum_red >> 1;
    end
`else
    sum_next = sum_red;
`endif
  end

  // ---------------------------------------------------------------------------
  // S1 register: raw add and subtract with one guard bit each.
  // Data is captured on every advance, valid or not; bubble data is
  // don't-care and gating it would only add enable logic.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (clear) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_dif   <= '0;
    end else if (adv1) begin
      s1_valid <= valid_i;
      s1_sum   <= {1'b0, u_i} + {1'b0, v_i};
      s1_dif   <= {1'b0, u_i} - {1'b0, v_i};
    end
  end

  // ---------------------------------------------------------------------------
  // S2 register: reduced results, held while the sink stalls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clear) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_dif   <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      s2_sum   <= sum_next;
      s2_dif   <= dif_next;
    end
  end

  assign valid_o = s2_valid;
  assign sum_o   = s2_sum;
  assign diff_o  = s2_dif;

endmodule

// File: tb/tb_ntt_gs_addsub_pipe.sv
// -----------------------------------------------------------------------------
// Self-checking bench for ntt_gs_addsub_pipe: reset state, table of wrap
// vectors with exact latency, backpressure stream, zeroize mid-stream, and a
// long random stream against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_ntt_gs_addsub_pipe;

  localparam int unsigned W = 23;
  localparam int unsigned P = 8380417;
  localparam int unsigned N_RANDOM = 10000;

  logic         clk;
  logic         rst;
  logic         zeroize;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] u_i;
  logic [W-1:0] v_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] sum_o;
  logic [W-1:0] diff_o;

  ntt_gs_addsub_pipe dut (
    .clk     (clk),
    .rst     (rst),
    .zeroize (zeroize),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .u_i     (u_i),
    .v_i     (v_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .diff_o  (diff_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned u;
    int unsigned v;
    int unsigned sum;
    int unsigned sum_half;
    int unsigned diff;
  } vec_t;

  typedef struct {
    int unsigned sum;
    int unsigned diff;
  } exp_t;

  int   checks;
  int   failures;
  vec_t tbl[9];
  exp_t exp_q[$];
  exp_t e;
  bit   hold_prev;
  int unsigned held_sum;
  int unsigned held_diff;
  int   n_out;
  int   n_in;
  int   cyc;
  bit   fired;
  bit   saw_block;
  int   k_next;

  // ---------------------------------------------------------------------------
  // Reference model: plain modular arithmetic on wide integers.
  // ---------------------------------------------------------------------------
  function automatic int unsigned model_sum(input int unsigned u, input int unsigned v);
    longint unsigned s;
    s = (longint'(u) + longint'(v)) % P;
`ifdef NTT_ADDSUB_SUM_DIV2_EN
    // Multiply by the inverse of 2 modulo P.
    s = (s * ((P + 1) / 2)) % P;
`endif
    return int'(s);
  endfunction

  function automatic int unsigned model_diff(input int unsigned u, input int unsigned v);
    longint unsigned d;
    d = (longint'(u) + P - longint'(v)) % P;
    return int'(d);
  endfunction

  function automatic int unsigned tbl_sum(input vec_t t);
`ifdef NTT_ADDSUB_SUM_DIV2_EN
    return t.sum_half;
`else
    return t.sum;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle observation of both handshakes, scoreboard compare on output
  // transfers, and stability check of held outputs. Caller pushes expected
  // values when in_fire is returned set.
  task automatic monitor_cycle(output bit in_fire);
    exp_t x;
    #3;
    in_fire = valid_i && ready_o;
    if (hold_prev) begin
      check("stall_valid_hold", valid_o, 1);
      check("stall_sum_hold", sum_o, held_sum);
      check("stall_diff_hold", diff_o, held_diff);
    end
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_output: got sum=%0d diff=%0d, expected no output", sum_o, diff_o);
      end else begin
        x = exp_q.pop_front();
        check("stream_sum", sum_o, x.sum);
        check("stream_diff", diff_o, x.diff);
        n_out++;
      end
    end
    hold_prev = valid_o && !ready_i;
    held_sum  = sum_o;
    held_diff = diff_o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    hold_prev = 1'b0;
    n_out     = 0;

    //        u        v        sum      sum_half diff
    tbl[0] = '{8380416, 1,       0,       0,       8380415};
    tbl[1] = '{0,       1,       1,       4190209, 8380416};
    tbl[2] = '{0,       0,       0,       0,       0};
    tbl[3] = '{8380416, 8380416, 8380415, 8380416, 0};
    tbl[4] = '{1,       8380416, 0,       0,       2};
    tbl[5] = '{4190208, 4190209, 0,       0,       8380416};
    tbl[6] = '{100,     30,      130,     65,      70};
    tbl[7] = '{8380416, 2,       1,       4190209, 8380414};
    tbl[8] = '{4,       6,       10,      5,       8380415};

    // ---------------- reset then idle ----------------
    rst = 1'b1; zeroize = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    u_i = '0; v_i = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_valid_o", valid_o, 0);
    check("reset_sum_o", sum_o, 0);
    check("reset_diff_o", diff_o, 0);
    check("reset_ready_o", ready_o, 1);
    tick();
    check("idle_valid_o", valid_o, 0);

    // ---------------- table: back-to-back, exact 2-cycle latency ----------------
    for (int t = 0; t < 11; t++) begin
      if (t < 9) begin
        valid_i = 1'b1; u_i = W'(tbl[t].u); v_i = W'(tbl[t].v);
      end else begin
        valid_i = 1'b0;
      end
      ready_i = 1'b1;
      #1;
      check("tbl_ready_o", ready_o, 1);
      if (t >= 2) begin
        check("tbl_valid_o", valid_o, 1);
        check("tbl_sum_o", sum_o, tbl_sum(tbl[t-2]));
        check("tbl_diff_o", diff_o, tbl[t-2].diff);
      end else begin
        check("tbl_latency_valid_o", valid_o, 0);
      end
      tick();
    end
    check("tbl_drain_valid_o", valid_o, 0);

    // ---------------- backpressure stream ----------------
    hold_prev = 1'b0; n_out = 0; k_next = 1; cyc = 0; saw_block = 1'b0;
    fired = 1'b0; valid_i = 1'b0;
    while ((k_next <= 6 || exp_q.size() > 0) && cyc < 200) begin
      if (!valid_i || fired) begin
        if (k_next <= 6) begin
          valid_i = 1'b1; u_i = W'(k_next); v_i = W'(2 * k_next);
        end else begin
          valid_i = 1'b0;
        end
      end
      ready_i = !(cyc >= 3 && cyc < 6);
      #1;
      if (!ready_i && !ready_o) saw_block = 1'b1;
      monitor_cycle(fired);
      if (fired) begin
        exp_q.push_back('{model_sum(k_next, 2 * k_next), P - k_next});
        k_next++;
      end
      cyc++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    check("bp_no_timeout", (cyc < 200), 1);
    check("bp_ready_o_blocked", saw_block, 1);
    check("bp_output_count", n_out, 6);

    // ---------------- zeroize with two pairs in flight ----------------
    hold_prev = 1'b0;
    valid_i = 1'b1; u_i = W'(10); v_i = W'(3); ready_i = 1'b1;
    tick();
    u_i = W'(20); v_i = W'(5);
    tick();
    valid_i = 1'b0; ready_i = 1'b0; zeroize = 1'b1;
    #1;
    check("zr_pre_valid_o", valid_o, 1);
    tick();
    zeroize = 1'b0; ready_i = 1'b1;
    #1;
    check("zr_valid_o", valid_o, 0);
    check("zr_sum_o", sum_o, 0);
    check("zr_diff_o", diff_o, 0);
    check("zr_ready_o", ready_o, 1);
    tick();
    check("zr_no_stale", valid_o, 0);
    valid_i = 1'b1; u_i = W'(7); v_i = W'(9);
    tick();
    valid_i = 1'b0;
    check("zr_new_latency", valid_o, 0);
    tick();
    check("zr_new_valid_o", valid_o, 1);
    check("zr_new_sum_o", sum_o, model_sum(7, 9));
    check("zr_new_diff_o", diff_o, model_diff(7, 9));
    tick();
    check("zr_new_done", valid_o, 0);

    // ---------------- random stream ----------------
    hold_prev = 1'b0; n_out = 0; n_in = 0; cyc = 0; fired = 1'b0;
    valid_i = 1'b0;
    while ((n_in < N_RANDOM || exp_q.size() > 0) && cyc < 60000) begin
      if (!valid_i || fired) begin
        if (n_in < N_RANDOM && $urandom_range(3) != 0) begin
          valid_i = 1'b1;
          u_i = W'($urandom_range(P - 1));
          v_i = W'($urandom_range(P - 1));
        end else begin
          valid_i = 1'b0;
        end
      end
      ready_i = (n_in >= N_RANDOM) ? 1'b1 : ($urandom_range(3) != 0);
      monitor_cycle(fired);
      if (fired) begin
        exp_q.push_back('{model_sum(u_i, v_i), model_diff(u_i, v_i)});
        n_in++;
      end
      cyc++;
    end
    valid_i = 1'b0;
    check("rnd_no_timeout", (cyc < 60000), 1);
    check("rnd_output_count", n_out, N_RANDOM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
